uart_rx_word_buffer: RTL

Downstream consumer of the UART receiver's byte output. Packs received bytes little-endian into 32-bit words and queues them in a DEPTH-entry FIFO. The CPU drains the FIFO through a show-ahead read port. Tracks lost words with a sticky overrun flag.

---
 rtl/uart_rx_word_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_rx_word_buffer.sv
// Purpose : packs UART receiver bytes little-endian into 32-bit words and queues
//           them in a DEPTH-entry FIFO drained by the CPU through a show-ahead port.
// Latency : byte -> partial_count next cycle; 4th byte -> rd_valid/level next cycle.
// Backpressure: none toward the UART; a completed word that finds the FIFO full
//           (and no same-cycle pop) is dropped and the sticky overrun flag is set.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   byte_valid/data   one-cycle byte strobe and byte from the UART receiver
//   flush             discard partial word and all queued words (overrun kept)
//   rd_en             pop request, ignored while rd_valid=0
//   clear_overrun     clear sticky overrun (a same-cycle drop wins)
//   rd_data/rd_valid  head-of-FIFO word and FIFO-not-empty
//   level             words stored, 0..DEPTH
//   partial_count     bytes held in the assembler, 0..3
//   overrun           sticky lost-word flag
module uart_rx_word_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  input  logic                       flush,
  input  logic                       rd_en,
  input  logic                       clear_overrun,
  output logic [31:0]                rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic [1:0]                 partial_count,
  output logic                       overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // Assembler state: byte index and the three lower bytes of the word in progress.
  logic [1:0]    byte_idx;
  logic [23:0]   hold;

  // FIFO storage; level is the single source of full/empty.
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          overrun_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic          word_done;
  logic          pop;
  logic          push;
  logic          drop;
  logic [31:0]   new_word;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LEVEL);

  // flush masks every byte and pop in its cycle, so gate the strobes here once.
  assign word_done = byte_valid && (byte_idx == 2'd3) && !flush;
  assign pop       = rd_en && !fifo_empty && !flush;

  // A same-cycle pop frees the slot a full FIFO needs, so the word still lands.
  assign push      = word_done && (!fifo_full || pop);
  assign drop      = word_done && fifo_full && !pop;

  assign new_word  = {byte_data, hold};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx  <= 2'd0;
      hold      <= 24'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      // Sticky flag: a drop in the same cycle as a clear keeps it set.
      // flush never produces a drop, so it leaves overrun untouched.
      overrun_q <= drop | (overrun_q & ~clear_overrun);

      if (flush) begin
        byte_idx <= 2'd0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level_q  <= '0;
      end else begin
        if (byte_valid) begin
          // Lanes 0..2 go to the holding register; lane 3 is consumed directly
          // into the pushed word. hold is deliberately not cleared after a word.
          case (byte_idx)
            2'd0:    hold[7:0]   <= byte_data;
            2'd1:    hold[15:8]  <= byte_data;
            2'd2:    hold[23:16] <= byte_data;
            default: ;
          endcase
          // Wraps 3 -> 0 whether the word was pushed or dropped.
          byte_idx <= byte_idx + 2'd1;
        end

        if (push) begin
          mem[wr_ptr] <= new_word;
          wr_ptr      <= wr_ptr + AW'(1);
        end

        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end

        if (push && !pop) begin
          level_q <= level_q + LW'(1);
        end else if (pop && !push) begin
          level_q <= level_q - LW'(1);
        end
      end
    end
  end

  // Show-ahead read: head word straight from the array, no output register.
  assign rd_data       = mem[rd_ptr];
  assign rd_valid      = !fifo_empty;
  assign level         = level_q;
  assign partial_count = byte_idx;
  assign overrun       = overrun_q;

endmodule
